bin_to_gray_stream: RTL and testbench

// - Binary-to-Gray encoder with valid/ready handshake; the encode side of our Gray-to-binary decoder.
// - Stream mode: encodes caller-supplied binary words. Count mode: emits successive Gray codes from an

---
 rtl/bin_to_gray_stream.sv | 184 ++++++++++++++++++
 tb/tb_bin_to_gray_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_gray_stream.sv
// bin_to_gray_stream: binary-to-Gray encoder with a valid/ready stream interface.
// Stream mode encodes caller words; count mode emits Gray codes of an internal counter.
// The output register is backed by a one-word skid register, so the block keeps full
// throughput and in_ready never depends combinationally on out_ready.
// Optional build macro: GRAY_SEQ_CHECK_EN adds a sticky single-bit-step checker on
// transferred output words (seq_err). Without it, seq_err is tied low.
module bin_to_gray_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cnt_mode,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_W  = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic             mode_q_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             in_ready_r;
  logic [WIDTH-1:0] count_r;
  logic             wrap_r;

  logic             stream_push_s;
  logic             gen_push_s;
  logic             push_s;
  logic [WIDTH-1:0] push_data_s;
  logic             pop_s;
  logic             out_valid_nxt_s;
  logic [WIDTH-1:0] out_data_nxt_s;
  logic             skid_valid_nxt_s;
  logic [WIDTH-1:0] skid_data_nxt_s;
  logic             mode_nxt_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_nxt_s;
  logic             in_ready_nxt_s;

  // Handshake decode: the generator stalls while a mode change is pending so the pipeline drains.
  always_comb begin
    stream_push_s = ena && in_valid && in_ready_r;
    gen_push_s    = ena && mode_q_r && cnt_mode && !skid_valid_r;
    push_s        = stream_push_s || gen_push_s;
    pop_s         = ena && out_valid_r && out_ready;
    if (mode_q_r) begin
      push_data_s = to_gray(count_r);
    end else begin
      push_data_s = to_gray(in_data);
    end
  end

  // Next-state for output/skid registers, counter, mode and the registered in_ready.
  always_comb begin
    out_valid_nxt_s  = out_valid_r;
    out_data_nxt_s   = out_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_data_nxt_s  = skid_data_r;
    mode_nxt_s       = mode_q_r;
    count_nxt_s      = count_r;
    if (ena) begin
      if (!out_valid_r || pop_s) begin
        if (skid_valid_r) begin
          out_valid_nxt_s  = 1'b1;
          out_data_nxt_s   = skid_data_r;
          skid_valid_nxt_s = 1'b0;
        end else if (push_s) begin
          out_valid_nxt_s = 1'b1;
          out_data_nxt_s  = push_data_s;
        end else begin
          out_valid_nxt_s = 1'b0;
        end
      end else if (push_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_data_nxt_s  = push_data_s;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
      if (cnt_clr) begin
        count_nxt_s = ZERO_W;
      end else if (gen_push_s) begin
        count_nxt_s = count_r + ONE_W;
      end else begin
        count_nxt_s = count_r;
      end
      // Mode may only switch with nothing in flight and nothing entering this cycle.
      if (!out_valid_r && !skid_valid_r && !push_s) begin
        mode_nxt_s = cnt_mode;
      end else begin
        mode_nxt_s = mode_q_r;
      end
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
    wrap_nxt_s     = gen_push_s && (count_r == MAX_W);
    in_ready_nxt_s = !skid_valid_nxt_s && !mode_nxt_s && (cnt_mode == mode_nxt_s);
  end

  // State registers; reset discards any in-flight words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= ZERO_W;
      skid_valid_r <= 1'b0;
      skid_data_r  <= ZERO_W;
      in_ready_r   <= 1'b0;
      count_r      <= ZERO_W;
      wrap_r       <= 1'b0;
    end else begin
      mode_q_r     <= mode_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      out_data_r   <= out_data_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      count_r      <= count_nxt_s;
      wrap_r       <= wrap_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign wrap      = wrap_r;

`ifdef GRAY_SEQ_CHECK_EN
  function automatic logic one_bit_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a ^ b;
    return (d != ZERO_W) && ((d & (d - ONE_W)) == ZERO_W);
  endfunction

  logic [WIDTH-1:0] last_r;
  logic             have_last_r;
  logic             seq_err_r;

  // Track the last transferred word; flag any transfer that is not a single-bit step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r      <= ZERO_W;
      have_last_r <= 1'b0;
      seq_err_r   <= 1'b0;
    end else if (ena) begin
      if (mode_nxt_s != mode_q_r) begin
        have_last_r <= 1'b0;
      end else if (pop_s) begin
        if (have_last_r && !one_bit_diff(out_data_r, last_r)) begin
          seq_err_r <= 1'b1;
        end else begin
          seq_err_r <= seq_err_r;
        end
        last_r      <= out_data_r;
        have_last_r <= 1'b1;
      end else begin
        have_last_r <= have_last_r;
      end
    end else begin
      seq_err_r <= seq_err_r;
    end
  end

  assign seq_err = seq_err_r;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray_stream.sv
// Self-checking bench for bin_to_gray_stream (WIDTH=8): directed spec scenarios plus
// randomized stream/count phases checked against a queue/counter reference model.
module tb_bin_to_gray_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, ena, cnt_mode, cnt_clr, in_valid, in_ready;
  logic         out_valid, out_ready, wrap, seq_err;
  logic [W-1:0] in_data, out_data;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] sb[$];
  int           k_exp = 0;
  int           clr_cd = 0;
  bit           count_phase = 1'b0;
  int           wrap_cnt = 0;
  int           wrap_base;
  logic         seq_exp;

  always #5 clk = ~clk;

  bin_to_gray_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cnt_mode(cnt_mode), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wrap(wrap), .seq_err(seq_err)
  );

  always @(negedge clk) if (!rst && wrap) wrap_cnt++;

  function automatic logic [W-1:0] gray(input int b);
    logic [W-1:0] v;
    v = b[W-1:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes implied by the current inputs/outputs, then advance.
  task automatic tick();
    if (!rst && ena && out_valid && out_ready) begin
      if (sb.size() > 0) begin
        check("stream_word", out_data, sb.pop_front());
      end else if (count_phase) begin
        check("count_word", out_data, gray(k_exp));
        k_exp = (k_exp + 1) % 256;
        if (clr_cd > 0) begin
          clr_cd--;
          if (clr_cd == 0) k_exp = 0;
        end
      end else begin
        check("unexpected_word", out_valid, 1'b0);
      end
    end
    if (!rst && ena && in_valid && in_ready) sb.push_back(gray(in_data));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
`ifdef GRAY_SEQ_CHECK_EN
    seq_exp = 1'b1;
`else
    seq_exp = 1'b0;
`endif
    rst = 1'b1; ena = 1'b1; cnt_mode = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_wrap", wrap, 1'b0);
    check("rst_seq_err", seq_err, 1'b0);
    rst = 1'b0;
    tick();
    check("first_in_ready", in_ready, 1'b1);

    // Sequence checker: Gray 0x00, 0x02 legal, then 0x01 is a two-bit step.
    out_ready = 1'b1;
    send(8'h00);
    send(8'h03);
    send(8'h01);
    in_valid = 1'b0;
    check("seq_ok", seq_err, 1'b0);
    tick();
    check("seq_set", seq_err, seq_exp);
    repeat (3) tick();
    check("seq_sticky", seq_err, seq_exp);

    // Back-to-back stream words, one-cycle latency.
    send(8'h05);
    check("lat_valid", out_valid, 1'b1);
    check("lat_0x05", out_data, 8'h07);
    send(8'hFF);
    check("lat_0xFF", out_data, 8'h80);
    in_valid = 1'b0;
    tick();

    // Backpressure fills the skid register.
    out_ready = 1'b0;
    send(8'h01);
    check("bp_ready_1", in_ready, 1'b1);
    send(8'h02);
    in_valid = 1'b0;
    check("bp_ready_drop", in_ready, 1'b0);
    repeat (3) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 8'h01);
    end
    out_ready = 1'b1;
    tick();
    check("bp_second", out_data, 8'h03);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    check("bp_drained", out_valid, 1'b0);

    // Randomized stream traffic.
    repeat (400) begin
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("stream_drain", out_valid, 1'b0);
    check("sb_empty", sb.size(), 0);

    // Count mode from a cleared counter; more than 256 pushes give exactly one wrap.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    k_exp = 0;
    count_phase = 1'b1;
    cnt_mode = 1'b1;
    wrap_base = wrap_cnt;
    repeat (300) tick();
    check("count_in_ready", in_ready, 1'b0);
    out_ready = 1'b0;
    repeat (4) tick();
    check("wrap_once", wrap_cnt - wrap_base, 1);

    // Clear while both stages hold words: those drain first, then the count restarts at 0.
    check("clr_head", out_data, gray(k_exp));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    clr_cd = 2;
    out_ready = 1'b1;
    repeat (20) tick();
    check("clr_applied", clr_cd, 0);

    // Randomized count-mode traffic.
    repeat (200) begin
      ena       = ($urandom_range(0, 7) != 0);
      out_ready = $urandom_range(0, 1);
      tick();
    end

    // Back to stream, then request count mode while the skid is full.
    ena = 1'b1; cnt_mode = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    count_phase = 1'b0;
    check("stream_again_ready", in_ready, 1'b1);
    check("stream_again_empty", out_valid, 1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    k_exp = 0;
    out_ready = 1'b0;
    send(8'h10);
    send(8'h20);
    in_valid = 1'b0;
    cnt_mode = 1'b1;
    count_phase = 1'b1;
    repeat (4) begin
      tick();
      check("mc_hold", out_data, 8'h18);
      check("mc_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    repeat (10) tick();
    check("mc_count_started", (k_exp >= 4), 1'b1);

    // Reset with both stages full: in-flight words vanish immediately.
    out_ready = 1'b0;
    repeat (3) tick();
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_ready", in_ready, 1'b0);
    cnt_mode = 1'b0;
    sb.delete();
    count_phase = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_no_stale", out_valid, 1'b0);
    end
    check("post_rst_ready", in_ready, 1'b1);
    check("post_rst_seq_err", seq_err, 1'b0);
    send(8'h33);
    in_valid = 1'b0;
    check("post_rst_word", out_data, 8'h2A);
    tick();
    check("post_rst_drained", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
